// File: rtl/meter_display_if.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | meter_display_if                                                     |
// | Bundle between the BCD time source and the seven-segment display     |
// | stage: packed-BCD time in, active-low anode/segment/dp drive out.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface meter_display_if;
  logic [15:0] bcd;  // digit3 = [15:12] ... digit0 = [3:0]
  logic [3:0]  an;   // active-low digit anodes
  logic [6:0]  seg;  // active-low cathodes, seg[0]=a .. seg[6]=g
  logic        dp;   // active-low decimal point

  // Time source side: drives the BCD value, may observe the display.
  modport master (output bcd, input an, input seg, input dp);
  // Display stage side.
  modport slave  (input bcd, output an, output seg, output dp);
endinterface

`default_nettype wire

// File: rtl/meter_display.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | meter_display                                                        |
// | Time-multiplexes a 4-digit packed-BCD remaining time onto a          |
// | common-anode seven-segment display, flashing slowly below 200 s and  |
// | fast at 0000. Optional leading-zero blanking: define METER_LZB_EN.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module meter_display #(
  parameter int SCAN_DIV   = 100000,   // clk cycles per digit slot, >= 2
  parameter int BLINK_HALF = 50000000  // clk cycles per blink tick, >= 2
) (
  input  logic           clk,
  input  logic           rst,
  meter_display_if.slave bus
);

  localparam int c_scan_w  = $clog2(SCAN_DIV);
  localparam int c_blink_w = $clog2(BLINK_HALF);
  localparam logic [c_scan_w-1:0]  c_scan_last  = c_scan_w'(SCAN_DIV - 1);
  localparam logic [c_blink_w-1:0] c_blink_last = c_blink_w'(BLINK_HALF - 1);

  typedef enum logic [1:0] {
    MODE_NORMAL = 2'd0,
    MODE_LOW    = 2'd1,
    MODE_ZERO   = 2'd2
  } mode_t;

  logic [15:0]          r_bcd_q;
  mode_t                r_mode;
  mode_t                w_mode;
  logic [c_scan_w-1:0]  r_scan_cnt;
  logic [1:0]           r_idx;
  logic [c_blink_w-1:0] r_blink_cnt;
  logic [1:0]           r_tick;
  logic [3:0]           r_an;
  logic [6:0]           r_seg;

  logic                 w_mode_chg;
  logic                 w_blank;
  logic                 w_suppress;
  logic [3:0]           w_nib;
  logic [6:0]           w_seg_dec;

  // Capture the counter's BCD value; every decision below uses this copy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_bcd_q <= 16'h0000;
    else     r_bcd_q <= bus.bcd;
  end

  // Classify the displayed time: 0000, 1..199, or anything else.
  always_comb begin
    w_mode = MODE_NORMAL;
    if (r_bcd_q == 16'h0000)
      w_mode = MODE_ZERO;
    else if ((r_bcd_q[15:12] == 4'd0) && (r_bcd_q[11:8] < 4'd2))
      w_mode = MODE_LOW;
  end

  assign w_mode_chg = (w_mode != r_mode);

  // Flash phase; the cycle a new mode is entered is forced visible so a
  // fresh warning always opens with the digits shown.
  always_comb begin
    w_blank = 1'b0;
    if (!w_mode_chg) begin
      case (w_mode)
        MODE_ZERO: w_blank = r_tick[0];
        MODE_LOW:  w_blank = r_tick[1];
        default:   w_blank = 1'b0;
      endcase
    end
  end

  assign w_nib = r_bcd_q[{r_idx, 2'b00} +: 4];

  // Nibble to active-low segments {g..a}; non-BCD nibbles show a dash.
  always_comb begin
    case (w_nib)
      4'd0:    w_seg_dec = 7'b1000000;
      4'd1:    w_seg_dec = 7'b1111001;
      4'd2:    w_seg_dec = 7'b0100100;
      4'd3:    w_seg_dec = 7'b0110000;
      4'd4:    w_seg_dec = 7'b0011001;
      4'd5:    w_seg_dec = 7'b0010010;
      4'd6:    w_seg_dec = 7'b0000010;
      4'd7:    w_seg_dec = 7'b1111000;
      4'd8:    w_seg_dec = 7'b0000000;
      4'd9:    w_seg_dec = 7'b0010000;
      default: w_seg_dec = 7'b0111111;
    endcase
  end

`ifdef METER_LZB_EN
  // Hide a digit when it and every more-significant digit are zero;
  // the units digit is always shown.
  always_comb begin
    case (r_idx)
      2'd3:    w_suppress = (r_bcd_q[15:12] == 4'd0);
      2'd2:    w_suppress = (r_bcd_q[15:8]  == 8'd0);
      2'd1:    w_suppress = (r_bcd_q[15:4]  == 12'd0);
      default: w_suppress = 1'b0;
    endcase
  end
`else
  assign w_suppress = 1'b0;
`endif

  // Digit scan: each digit holds its slot for SCAN_DIV cycles, 0->1->2->3.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scan_cnt <= '0;
      r_idx      <= 2'd0;
    end else if (r_scan_cnt == c_scan_last) begin
      r_scan_cnt <= '0;
      r_idx      <= r_idx + 2'd1;
    end else begin
      r_scan_cnt <= r_scan_cnt + c_scan_w'(1);
    end
  end

  // Blink timebase and mode tracking; a mode change restarts the blink
  // phase and takes priority over a coincident tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_blink_cnt <= '0;
      r_tick      <= 2'd0;
      r_mode      <= MODE_NORMAL;
    end else begin
      r_mode <= w_mode;
      if (w_mode_chg) begin
        r_blink_cnt <= '0;
        r_tick      <= 2'd0;
      end else if (r_blink_cnt == c_blink_last) begin
        r_blink_cnt <= '0;
        r_tick      <= r_tick + 2'd1;
      end else begin
        r_blink_cnt <= r_blink_cnt + c_blink_w'(1);
      end
    end
  end

  // Registered display drive: all dark when blanked or suppressed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_an  <= 4'b1111;
      r_seg <= 7'b1111111;
    end else if (w_blank || w_suppress) begin
      r_an  <= 4'b1111;
      r_seg <= 7'b1111111;
    end else begin
      r_an  <= ~(4'b0001 << r_idx);
      r_seg <= w_seg_dec;
    end
  end

  assign bus.an  = r_an;
  assign bus.seg = r_seg;
  assign bus.dp  = 1'b1;

endmodule

`default_nettype wire

// File: tb/tb_meter_display.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_meter_display                                                     |
// | Scoreboard bench for meter_display (SCAN_DIV=4, BLINK_HALF=8).       |
// | Expectations honour METER_LZB_EN when it is defined.                 |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_meter_display;

  logic clk = 1'b0;
  logic rst = 1'b1;

  meter_display_if bus();

  meter_display #(.SCAN_DIV(4), .BLINK_HALF(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Posedge count; outputs are sampled on the following negedge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;   // negedge to check at; -1 = check immediately
    logic [3:0] an;
    logic [6:0] seg;
    string      name;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   B     = 0;   // cyc at the negedge just before the last reset release
  event imm_ev;

  function automatic logic [6:0] dec(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  task automatic push(input int c, input logic [3:0] an, input logic [6:0] seg,
                      input string nm);
    exp_t e;
    e.cyc = c; e.an = an; e.seg = seg; e.name = nm;
    q.push_back(e);
  endtask

  task automatic push_blank(input int a, input int b, input string nm);
    for (int c = a; c <= b; c++) push(c, 4'b1111, 7'b1111111, nm);
  endtask

  // Visible display of value v: digit slot i is active on output cycles
  // B+1+4*k .. B+4+4*k with i = k mod 4.
  task automatic push_vis(input int a, input int b, input logic [15:0] v,
                          input string nm);
    for (int c = a; c <= b; c++) begin
      int         i;
      logic [3:0] nib;
      logic       sup;
      i   = ((c - B - 1) >> 2) & 3;
      nib = v[i*4 +: 4];
      sup = 1'b0;
`ifdef METER_LZB_EN
      if (i == 3) sup = (v[15:12] == 4'd0);
      if (i == 2) sup = (v[15:8]  == 8'd0);
      if (i == 1) sup = (v[15:4]  == 12'd0);
`endif
      if (sup) push(c, 4'b1111, 7'b1111111, nm);
      else     push(c, ~(4'b0001 << i), dec(nib), nm);
    end
  endtask

  task automatic wait_to(input int x);
    while (cyc < x) @(negedge clk);
  endtask

  // Monitor: pops and compares whatever is due at this sample point.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk or imm_ev);
      while (q.size() > 0 && (q[0].cyc < 0 || q[0].cyc <= cyc)) begin
        e = q.pop_front();
        n_cmp++;
        if (e.cyc >= 0 && e.cyc != cyc) begin
          n_bad++;
          $display("FAIL %s: sampled at cyc %0d, required cyc %0d", e.name, cyc, e.cyc);
        end else if (bus.an !== e.an || bus.seg !== e.seg || bus.dp !== 1'b1) begin
          n_bad++;
          $display("FAIL %s @cyc %0d: an=%b seg=%b dp=%b, expected an=%b seg=%b dp=1",
                   e.name, cyc, bus.an, bus.seg, bus.dp, e.an, e.seg);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d checks pending", q.size());
    $fatal(1, "watchdog expired");
  end

  // Stimulus
  initial begin
    int C, D, E, G, H, R;
    bus.bcd = 16'h1234;
    rst     = 1'b1;
    repeat (2) @(negedge clk);
    push_blank(cyc + 1, cyc + 1, "reset_state");
    @(negedge clk);
    rst = 1'b0;
    B   = cyc;

    // NORMAL 1234: first output still decodes the reset bcd_q (0).
    push(B + 1, 4'b1110, 7'b1000000, "first_after_reset");
    push_vis(B + 2, B + 40, 16'h1234, "normal_1234");
    wait_to(B + 40);

    // LOW 0150: 16 visible / 16 blanked after entry.
    C = cyc;
    bus.bcd = 16'h0150;
    D = C + 2;
    push_vis(C + 1, C + 1, 16'h1234, "low_latency_old");
    push_vis(D, D + 16, 16'h0150, "low_visible");
    push_blank(D + 17, D + 32, "low_blank");
    push_vis(D + 33, D + 48, 16'h0150, "low_visible2");
    push_blank(D + 49, D + 52, "low_blank2");
    wait_to(D + 52);

    // Switch to 0000 while blanked: visible 2 cycles later, 8/8 flash.
    E = cyc;
    bus.bcd = 16'h0000;
    push_blank(E + 1, E + 1, "zero_switch_still_blank");
    push_vis(E + 2, E + 10, 16'h0000, "zero_visible");
    push_blank(E + 11, E + 18, "zero_blank");
    push_vis(E + 19, E + 26, 16'h0000, "zero_visible2");
    push_blank(E + 27, E + 28, "zero_blank2");
    wait_to(E + 28);

    // Illegal nibble: digit1 shows a dash (value is in LOW mode).
    G = cyc;
    bus.bcd = 16'h00A5;
    push_blank(G + 1, G + 1, "a5_old_zero_blank");
    push_vis(G + 2, G + 18, 16'h00A5, "illegal_dash");
    wait_to(G + 18);

    // Back to NORMAL, then an asynchronous reset pulse mid-frame.
    H = cyc;
    bus.bcd = 16'h1234;
    push_blank(H + 1, H + 1, "a5_low_blank");
    push_vis(H + 2, H + 8, 16'h1234, "normal_again");
    wait_to(H + 8);

    R = cyc;
    #2;
    rst = 1'b1;
    #0.5;
    push(-1, 4'b1111, 7'b1111111, "async_reset");
    ->imm_ev;
    #0.5;
    rst = 1'b0;
    B = R;
    push(R + 1, 4'b1110, 7'b1000000, "post_reset_first");
    push_vis(R + 2, R + 12, 16'h1234, "post_reset_scan");
    wait_to(R + 12);

    for (int k = 0; k < 20 && q.size() > 0; k++) @(negedge clk);
    if (q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d checks pending, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/meter_display.md
# meter_display

Downstream display stage for the parking-meter BCD counter. It takes the counter's 16-bit packed-BCD remaining time and time-multiplexes it onto the board's 4-digit common-anode seven-segment display. It applies the meter's warning behaviour: slow flash below 200 s and fast flash at 0000. All outputs are registered; the block only reads the counter's BCD output and never feeds back into it.

## Interface
Parameters:
- SCAN_DIV, 100000 — clk cycles each digit stays active (1 ms at 100 MHz); must be ≥ 2.
- BLINK_HALF, 50000000 — clk cycles per blink tick (0.5 s at 100 MHz); must be ≥ 2.

Ports:
- clk  in  1  system clock; only clock in the block.
- rst  in  1  asynchronous, active-high reset.
- bcd  in  16  packed BCD time, digit3 = bcd[15:12] (thousands) … digit0 = bcd[3:0] (units).
- an  out  4  digit anodes, active-low; an[i] drives digit i.
- seg  out  7  segment cathodes, active-low, seg[0]=a … seg[6]=g.
- dp  out  1  decimal point, active-low; held 1 (off).

## Operation
- Input stage: bcd registered every cycle into bcd_q. All decisions use bcd_q only.
- Mode is combinational from bcd_q:
  - ZERO when bcd_q == 16'h0000.
  - LOW when bcd_q[15:12] == 0, bcd_q[11:8] < 2, and not ZERO. This covers 1–199.
  - NORMAL otherwise.
- Scan counter: counts 0..SCAN_DIV-1. On terminal count it wraps to 0 and the digit index advances 0→1→2→3→0.
- Blink counter: counts 0..BLINK_HALF-1. On terminal count it wraps and the 2-bit tick counter increments modulo 4.
- Blanking:
  - ZERO: blanked when tick[0] = 1, giving 0.5 s on / 0.5 s off.
  - LOW: blanked when tick[1] = 1, giving 1 s on / 1 s off.
  - NORMAL: never blanked.
- Mode change: when the registered mode differs from the current mode, the blink counter and tick clear to 0 in the same cycle. A newly entered warning mode therefore always starts in the visible phase.
- Output register:
  - When blanked: an = 4'b1111 and seg = 7'b1111111.
  - Otherwise: an = ~(1 << index), and seg is the decode of the indexed nibble.
- Decode, active-low seg{g..a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Nibbles A–F decode to a dash, seg = 0111111 (g only). This is a visible error indication, not an X.
- Scan and blink counters are independent. Blanking does not stop the scan.

## Timing
- Reset values: an = 4'b1111, seg = 7'b1111111, dp = 1, index 0, bcd_q 0, all counters 0, mode register NORMAL.
- Effect of bcd_q = 0 at reset: mode evaluates to ZERO on the first cycle after reset. That is a mode change, so the blink state clears and the display starts visible.
- Latency: a bcd change reaches seg 2 cycles later while the affected digit is active (bcd_q register, then output register).
- Index to anode: an reflects a new index 1 cycle after the scan terminal count.
- Blink boundary: blanking takes effect on the output 1 cycle after the tick update.
- Reset asserted mid-scan or mid-blink: all state returns immediately, without waiting for a clock edge, to the reset values listed above.
- Simultaneous mode change and blink terminal count: the mode-change clear wins; tick = 0.

## Configuration
- METER_LZB_EN defined: leading-zero blanking is enabled.
  - When digit3 is 0, its anode stays inactive (1) during its slot.
  - Digit2 likewise, when digit3 and digit2 are both 0.
  - Digit1 likewise, when digit3, digit2 and digit1 are all 0.
  - Digit0 is never suppressed. ZERO mode therefore shows a single flashing "0".
- METER_LZB_EN undefined: all four digits are always driven, including leading zeros.

## Test plan
All scenarios use SCAN_DIV = 4 and BLINK_HALF = 8.
- Reset, then bcd = 16'h1234 held → an cycles 1110, 1101, 1011, 0111, each for 4 cycles; seg matches 4, 3, 2, 1 in order; never blanked.
- bcd = 16'h0150 → LOW mode; visible 16 cycles, blanked 16 cycles, repeating.
- bcd = 16'h0000 → ZERO mode; visible 8 cycles, blanked 8 cycles; with METER_LZB_EN, only an[0] is ever asserted.
- bcd switches from 16'h0150 to 16'h0000 while blanked → visible again within 3 cycles; blink restarts at tick = 0.
- bcd = 16'h00A5 (illegal nibble) → digit1 shows seg = 0111111; without METER_LZB_EN, digits 3 and 2 show 0.
- rst pulsed high for 1 ns mid-frame → an = 1111 and seg = 1111111 immediately, before the next clk edge; scan resumes at index 0.
